// File: rtl/seven_segment_decoder_if.sv
// Display-side bundle for the seven-segment receive decoder: pins in, decoded pair out.
interface seven_segment_decoder_if;
  logic [6:0] segments_in;
  logic       digit_in;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       valid;
  logic       error;
  logic       stall;

  modport master (
    output segments_in, digit_in,
    input  ten_count, unit_count, valid, error, stall
  );

  modport slave (
    input  segments_in, digit_in,
    output ten_count, unit_count, valid, error, stall
  );
endinterface

// File: rtl/seven_segment_decoder.sv
// Receive side of a two-digit multiplexed seven-segment bus: filter, decode, pair up digits.
// Define SEVEN_SEGMENT_DECODER_SYNC_EN to add a 2-flop input synchronizer (+2 cycles latency).
module seven_segment_decoder #(
  parameter int unsigned STABLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                    clk,
  input logic                    reset_n,
  seven_segment_decoder_if.slave disp
);

  localparam logic [3:0]  StableMax  = 4'(STABLE_CYCLES);
  localparam logic [15:0] TimeoutMax = 16'(TIMEOUT_CYCLES);

  typedef enum logic {StWaitUnits, StWaitTens} state_e;

  logic [6:0] w_seg_s;
  logic       w_dig_s;

`ifdef SEVEN_SEGMENT_DECODER_SYNC_EN
  logic [6:0] r_seg_meta, r_seg_sync;
  logic       r_dig_meta, r_dig_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_seg_meta <= '0;
      r_seg_sync <= '0;
      r_dig_meta <= 1'b0;
      r_dig_sync <= 1'b0;
    end else begin
      r_seg_meta <= disp.segments_in;
      r_seg_sync <= r_seg_meta;
      r_dig_meta <= disp.digit_in;
      r_dig_sync <= r_dig_meta;
    end
  end

  assign w_seg_s = ~r_seg_sync;
  assign w_dig_s = r_dig_sync;
`else
  assign w_seg_s = ~disp.segments_in;
  assign w_dig_s = disp.digit_in;
`endif

  // Returns {ok, bcd}; patterns are active-high, bit6=g .. bit0=a.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0111111: decode = {1'b1, 4'd0};
      7'b0000110: decode = {1'b1, 4'd1};
      7'b1011011: decode = {1'b1, 4'd2};
      7'b1001111: decode = {1'b1, 4'd3};
      7'b1100110: decode = {1'b1, 4'd4};
      7'b1101101: decode = {1'b1, 4'd5};
      7'b1111100: decode = {1'b1, 4'd6};
      7'b0000111: decode = {1'b1, 4'd7};
      7'b1111111: decode = {1'b1, 4'd8};
      7'b1100111: decode = {1'b1, 4'd9};
      default:    decode = {1'b0, 4'd0};
    endcase
  endfunction

  logic        r_dig_prev, r_captured, r_valid, r_error, r_stall;
  logic [6:0]  r_seg_prev;
  logic [3:0]  r_stab, r_shadow, r_ten, r_unit;
  logic [15:0] r_timeout;
  state_e      r_state;

  logic        w_toggle, w_restart, w_capture, w_captured_next, w_stall_next;
  logic        w_dec_ok, w_valid_d, w_error_d;
  logic [3:0]  w_dec_val, w_stab_next, w_shadow_d, w_ten_d, w_unit_d;
  logic [15:0] w_timeout_next;
  state_e      w_state_d;

  assign w_toggle  = (w_dig_s != r_dig_prev);
  assign w_restart = w_toggle || (w_seg_s != r_seg_prev);
  assign w_stab_next = w_restart ? 4'd1 :
                       (r_stab >= StableMax) ? StableMax : r_stab + 4'd1;
  // One capture per phase: a seg change after capture restarts the count but must not re-fire.
  assign w_capture       = (w_stab_next == StableMax) && (w_toggle || !r_captured);
  assign w_captured_next = w_capture || (r_captured && !w_toggle);

  assign w_timeout_next = w_toggle ? 16'd0 :
                          (r_timeout >= TimeoutMax) ? TimeoutMax : r_timeout + 16'd1;
  assign w_stall_next   = (w_timeout_next == TimeoutMax);

  assign {w_dec_ok, w_dec_val} = decode(w_seg_s);

  always_comb begin
    w_state_d  = r_state;
    w_shadow_d = r_shadow;
    w_ten_d    = r_ten;
    w_unit_d   = r_unit;
    w_valid_d  = 1'b0;
    w_error_d  = 1'b0;
    if (w_stall_next) begin
      w_state_d = StWaitUnits;
    end else if (w_capture) begin
      unique case (r_state)
        StWaitUnits: begin
          if (!w_dig_s) begin
            if (w_dec_ok) begin
              w_shadow_d = w_dec_val;
              w_state_d  = StWaitTens;
            end else begin
              w_error_d = 1'b1;
            end
          end
        end
        StWaitTens: begin
          if (w_dig_s) begin
            w_state_d = StWaitUnits;
            if (w_dec_ok) begin
              w_ten_d   = w_dec_val;
              w_unit_d  = r_shadow;
              w_valid_d = 1'b1;
            end else begin
              w_error_d = 1'b1;
            end
          end else if (w_dec_ok) begin
            w_shadow_d = w_dec_val;
          end else begin
            w_error_d = 1'b1;
            w_state_d = StWaitUnits;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dig_prev <= 1'b0;
      r_seg_prev <= '0;
      r_stab     <= '0;
      r_captured <= 1'b0;
      r_timeout  <= '0;
      r_state    <= StWaitUnits;
      r_shadow   <= '0;
      r_ten      <= '0;
      r_unit     <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_stall    <= 1'b0;
    end else begin
      r_dig_prev <= w_dig_s;
      r_seg_prev <= w_seg_s;
      r_stab     <= w_stab_next;
      r_captured <= w_captured_next;
      r_timeout  <= w_timeout_next;
      r_state    <= w_state_d;
      r_shadow   <= w_shadow_d;
      r_ten      <= w_ten_d;
      r_unit     <= w_unit_d;
      r_valid    <= w_valid_d;
      r_error    <= w_error_d;
      r_stall    <= w_stall_next;
    end
  end

  assign disp.ten_count  = r_ten;
  assign disp.unit_count = r_unit;
  assign disp.valid      = r_valid;
  assign disp.error      = r_error;
  assign disp.stall      = r_stall;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Randomized bench for seven_segment_decoder: two instances (STABLE_CYCLES 1 and 3) share pins.
module tb_seven_segment_decoder;

  localparam int unsigned Timeout = 255;
`ifdef SEVEN_SEGMENT_DECODER_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] drv_seg = 7'h7f;
  logic       drv_dig = 1'b0;

  always #5 clk = ~clk;

  seven_segment_decoder_if u_if_a ();
  seven_segment_decoder_if u_if_b ();

  assign u_if_a.segments_in = drv_seg;
  assign u_if_a.digit_in    = drv_dig;
  assign u_if_b.segments_in = drv_seg;
  assign u_if_b.digit_in    = drv_dig;

  seven_segment_decoder #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(Timeout)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .disp    (u_if_a.slave)
  );

  seven_segment_decoder #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(Timeout)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .disp    (u_if_b.slave)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: per instance, history-based view of the spec rules.
  logic [6:0] pat [10];
  int         m_stable [2];
  logic [6:0] m_seg [2];
  logic       m_dig [2];
  int         m_run [2];
  bit         m_capd [2];
  int         m_idle [2];
  bit         m_wait_tens [2];
  logic [3:0] m_shadow [2];
  logic [3:0] m_ten [2];
  logic [3:0] m_unit [2];
  bit         m_valid [2];
  bit         m_error [2];
  bit         m_stall [2];
  logic [6:0] p_seg [$];
  logic       p_dig [$];

  function automatic int decode_ref(logic [6:0] s);
    for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [6:0] pins_of(int d);
    logic [6:0] p;
    p = pat[d];
    return ~p;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_seg[m] = '0; m_dig[m] = 1'b0; m_run[m] = 0; m_capd[m] = 1'b0; m_idle[m] = 0;
      m_wait_tens[m] = 1'b0; m_shadow[m] = '0; m_ten[m] = '0; m_unit[m] = '0;
      m_valid[m] = 1'b0; m_error[m] = 1'b0; m_stall[m] = 1'b0;
    end
    p_seg.delete();
    p_dig.delete();
    for (int i = 0; i < SyncLat; i++) begin
      p_seg.push_back(7'h00);
      p_dig.push_back(1'b0);
    end
  endtask

  task automatic model_step(input logic [6:0] pins, input logic dig);
    logic [6:0] seg;
    logic       d;
    bit         tog, cap;
    int         v;
    p_seg.push_back(pins);
    p_dig.push_back(dig);
    seg = ~p_seg.pop_front();
    d   = p_dig.pop_front();
    for (int m = 0; m < 2; m++) begin
      tog = (d != m_dig[m]);
      if (tog) begin
        m_run[m] = 1; m_capd[m] = 1'b0; m_idle[m] = 0;
      end else begin
        m_run[m]  = (seg == m_seg[m]) ? m_run[m] + 1 : 1;
        m_idle[m] = (m_idle[m] < Timeout) ? m_idle[m] + 1 : Timeout;
      end
      m_seg[m] = seg;
      m_dig[m] = d;
      cap = (m_run[m] >= m_stable[m]) && !m_capd[m];
      if (cap) m_capd[m] = 1'b1;
      m_stall[m] = (m_idle[m] >= Timeout);
      m_valid[m] = 1'b0;
      m_error[m] = 1'b0;
      v = decode_ref(seg);
      if (m_stall[m]) begin
        m_wait_tens[m] = 1'b0;
      end else if (cap) begin
        if (!m_wait_tens[m]) begin
          if (!d) begin
            if (v < 0) m_error[m] = 1'b1;
            else begin m_shadow[m] = 4'(v); m_wait_tens[m] = 1'b1; end
          end
        end else if (d) begin
          m_wait_tens[m] = 1'b0;
          if (v < 0) m_error[m] = 1'b1;
          else begin m_ten[m] = 4'(v); m_unit[m] = m_shadow[m]; m_valid[m] = 1'b1; end
        end else if (v >= 0) begin
          m_shadow[m] = 4'(v);
        end else begin
          m_error[m] = 1'b1; m_wait_tens[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic [6:0] pins, input logic dig, input logic rst_n);
    @(negedge clk);
    drv_seg = pins;
    drv_dig = dig;
    reset_n = rst_n;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(pins, dig);
    #1;
  endtask

  function automatic logic [10:0] obs(int m);
    if (m == 0)
      return {u_if_a.valid, u_if_a.error, u_if_a.stall, u_if_a.ten_count, u_if_a.unit_count};
    return {u_if_b.valid, u_if_b.error, u_if_b.stall, u_if_b.ten_count, u_if_b.unit_count};
  endfunction

  function automatic logic [10:0] expv(int m);
    return {m_valid[m], m_error[m], m_stall[m], m_ten[m], m_unit[m]};
  endfunction

  task automatic test_reset();
    step(7'h7f, 1'b0, 1'b0);
    step(7'h7f, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (obs(m) !== expv(m)) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h want %h", m, obs(m), expv(m));
      end
    end
    n_cmp++;
    if (obs(0) !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_zero: got %h want %h", obs(0), 11'h000);
    end
  endtask

  task automatic test_pair();
    int first = -1;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) step(7'b0110000, 1'b0, 1'b1);
      else        step(7'b1111000, 1'b1, 1'b1);
      if (first < 0 && u_if_a.valid === 1'b1) first = k;
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL pair k%0d dut%0d: got %h want %h", k, m, obs(m), expv(m));
        end
      end
    end
    n_cmp++;
    if (first !== 2 + SyncLat) begin
      n_fail++;
      $display("FAIL pair_latency: got %0d want %0d", first, 2 + SyncLat);
    end
    n_cmp++;
    if ({u_if_a.ten_count, u_if_a.unit_count} !== 8'h73) begin
      n_fail++;
      $display("FAIL pair_value: got %h want 73", {u_if_a.ten_count, u_if_a.unit_count});
    end
  endtask

  task automatic test_invalid();
    int errs = 0, vals = 0;
    for (int k = 0; k < 5; k++) begin
      step(7'b1111111, 1'b0, 1'b1);
      errs += int'(u_if_a.error);
      vals += int'(u_if_a.valid);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL invalid k%0d dut%0d: got %h want %h", k, m, obs(m), expv(m));
        end
      end
    end
    n_cmp++;
    if (errs != 1 || vals != 0 || {u_if_a.ten_count, u_if_a.unit_count} !== 8'h73) begin
      n_fail++;
      $display("FAIL invalid_summary: got err=%0d val=%0d pair=%h want err=1 val=0 pair=73",
               errs, vals, {u_if_a.ten_count, u_if_a.unit_count});
    end
  endtask

  task automatic test_timeout();
    int first = -1, vals = 0;
    step(pins_of(1), 1'b1, 1'b1);
    step(pins_of(5), 1'b0, 1'b1);
    for (int k = 1; k <= Timeout + 6; k++) begin
      step(pins_of(5), 1'b0, 1'b1);
      if (first < 0 && u_if_a.stall === 1'b1) first = k;
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL timeout k%0d dut%0d: got %h want %h", k, m, obs(m), expv(m));
        end
      end
    end
    n_cmp++;
    if (first != Timeout + SyncLat) begin
      n_fail++;
      $display("FAIL stall_onset: got %0d want %0d", first, Timeout + SyncLat);
    end
    // Tens after stall must not pair with the discarded units shadow.
    for (int k = 0; k < 4 + SyncLat; k++) begin
      step(pins_of(2), 1'b1, 1'b1);
      vals += int'(u_if_a.valid);
      if (k == SyncLat) begin
        n_cmp++;
        if (u_if_a.stall !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_clear: got %b want 0", u_if_a.stall);
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      step((k < 3) ? pins_of(4) : pins_of(6), (k < 3) ? 1'b0 : 1'b1, 1'b1);
      vals += int'(u_if_a.valid);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL resume k%0d dut%0d: got %h want %h", k, m, obs(m), expv(m));
        end
      end
    end
    for (int k = 0; k < SyncLat; k++) begin
      step(pins_of(6), 1'b1, 1'b1);
      vals += int'(u_if_a.valid);
    end
    n_cmp++;
    if (vals != 1 || {u_if_a.ten_count, u_if_a.unit_count} !== 8'h64) begin
      n_fail++;
      $display("FAIL resume_pair: got val=%0d pair=%h want val=1 pair=64",
               vals, {u_if_a.ten_count, u_if_a.unit_count});
    end
  endtask

  task automatic test_reset_mid();
    int vals = 0;
    for (int k = 0; k < 1 + SyncLat; k++) step(pins_of(5), 1'b0, 1'b1);
    step(pins_of(5), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(pins_of(2), 1'b1, 1'b1);
      vals += int'(u_if_a.valid);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL reset_mid k%0d dut%0d: got %h want %h", k, m, obs(m), expv(m));
        end
      end
    end
`ifndef SEVEN_SEGMENT_DECODER_SYNC_EN
    n_cmp++;
    if (vals != 0 || {u_if_a.ten_count, u_if_a.unit_count} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_pair: got val=%0d pair=%h want val=0 pair=00",
               vals, {u_if_a.ten_count, u_if_a.unit_count});
    end
`endif
  endtask

  task automatic test_glitch();
    logic [6:0] seq [12];
    logic       dg [12];
    int         vals_glitch = 0, vals_clean = 0;
    for (int k = 0; k < 3; k++) begin seq[k] = pins_of(9); dg[k] = 1'b1; end
    seq[3] = pins_of(1); seq[4] = pins_of(8); seq[5] = pins_of(1);
    for (int k = 3; k < 6; k++) dg[k] = 1'b0;
    for (int k = 6; k < 9; k++) begin seq[k] = pins_of(9); dg[k] = 1'b1; end
    for (int k = 9; k < 12; k++) begin seq[k] = pins_of(4); dg[k] = 1'b0; end
    for (int k = 0; k < 12 + SyncLat; k++) begin
      if (k < 12) step(seq[k], dg[k], 1'b1);
      else        step(pins_of(4), 1'b0, 1'b1);
      if (k >= 3 + SyncLat) vals_glitch += int'(u_if_b.valid);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL glitch k%0d dut%0d: got %h want %h", k, m, obs(m), expv(m));
        end
      end
    end
    for (int k = 0; k < 5 + SyncLat; k++) begin
      step(pins_of(9), 1'b1, 1'b1);
      vals_clean += int'(u_if_b.valid);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL clean k%0d dut%0d: got %h want %h", k, m, obs(m), expv(m));
        end
      end
    end
    n_cmp++;
    if (vals_glitch != 0 || vals_clean != 1 || {u_if_b.ten_count, u_if_b.unit_count} !== 8'h94) begin
      n_fail++;
      $display("FAIL stable3: got glitch_val=%0d clean_val=%0d pair=%h want 0 1 94",
               vals_glitch, vals_clean, {u_if_b.ten_count, u_if_b.unit_count});
    end
  endtask

  task automatic test_random();
    int         left = 0;
    logic [6:0] cur = 7'h7f;
    logic [6:0] pins;
    logic       d;
    logic       rst_n;
    d = drv_dig;
    for (int i = 0; i < 1500; i++) begin
      if (left == 0) begin
        d = ~d;
        left = ($urandom_range(0, 99) < 2) ? int'($urandom_range(260, 300))
                                           : int'($urandom_range(1, 5));
        cur = ($urandom_range(0, 19) == 0) ? 7'($urandom) : pins_of(int'($urandom_range(0, 9)));
      end
      pins  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : cur;
      rst_n = ($urandom_range(0, 199) != 0);
      step(pins, d, rst_n);
      left--;
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (obs(m) !== expv(m)) begin
          n_fail++;
          $display("FAIL random i%0d dut%0d: got %h want %h", i, m, obs(m), expv(m));
        end
      end
    end
  endtask

  initial begin
    pat = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};
    m_stable = '{1, 3};
    model_reset();
    test_reset();
    test_pair();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
